dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 64, SHALL be the width of the requester and memory byte addresses.
REQ-002 Parameter DATA_W, default 64, SHALL be the width of all data buses.
REQ-003 Parameter MEM_LAT, default 2, SHALL be the number of cycles the memory controls are held per access; legal range is 1..15.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 req0, req1  input  1  SHALL be the access requests from port 0 (fetch/load-store A) and port 1 (B).
REQ-007 we0, we1  input  1  SHALL select write (1) or read (0) for the matching port.
REQ-008 addr0, addr1  input  ADDR_W  SHALL be the byte addresses, forwarded unmodified.
REQ-009 wdata0, wdata1  input  DATA_W  SHALL be the write data.
REQ-010 gnt0, gnt1  output  1  SHALL be one-cycle pulses marking acceptance of the port's request.
REQ-011 ack0, ack1  output  1  SHALL be one-cycle pulses marking completion of the port's access.
REQ-012 rdata0, rdata1  output  DATA_W  SHALL be the read result, valid while the matching ack is high.
REQ-013 mem_addr  output  ADDR_W  SHALL be the address driven to the shared data memory.
REQ-014 mem_wdata  output  DATA_W  SHALL be the write data driven to the memory.
REQ-015 mem_read, mem_write  output  1  SHALL be the memory read and write strobes.
REQ-016 mem_rdata  input  DATA_W  SHALL be the combinational read data returned by the memory.
REQ-017 busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-018 The FSM SHALL have the states IDLE, BUSY and DONE.
REQ-019 In IDLE, when any req is high at a rising edge: select a winner, latch its we, addr and wdata, load the cycle counter with MEM_LAT-1, and enter BUSY.
REQ-020 The winner's gnt SHALL be high for exactly the first BUSY cycle; the requester SHALL hold req, we, addr and wdata stable until gnt.
REQ-021 In BUSY, mem_addr and mem_wdata SHALL carry the latched values; mem_read SHALL be high in every BUSY cycle of a read.
REQ-022 For a write, mem_write SHALL be high only in the first BUSY cycle.
REQ-023 At the end of the BUSY cycle in which the counter is 0, a read SHALL capture mem_rdata into the winner's rdata, and the FSM SHALL enter DONE.
REQ-024 In DONE, the winner's ack SHALL be high for one cycle, after which the FSM SHALL return to IDLE; no request is accepted in DONE.
REQ-025 Timing: req sampled in IDLE at the edge ending cycle c gives gnt in cycle c+1 and ack in cycle c+MEM_LAT+1; throughput is one access per MEM_LAT+2 cycles.
REQ-026 For a write, rdata SHALL be 0 while ack is high; rdata of the non-acked port SHALL hold its previous value.
REQ-027 When exactly one req is high, that port SHALL win.
REQ-028 On simultaneous requests, the winner SHALL be chosen per REQ-035/REQ-036; the loser's req stays pending and SHALL be served at the next IDLE.
REQ-029 Outside BUSY, mem_read, mem_write, all gnt and all ack SHALL be low, except ack in DONE; mem_addr and mem_wdata SHALL hold their last values.
REQ-030 A req deasserted before gnt SHALL be treated as withdrawn, with no access and no ack.

Reset
REQ-031 Reset SHALL force the state to IDLE and the counter to 0 immediately.
REQ-032 Reset SHALL immediately force low: gnt0, gnt1, ack0, ack1, mem_read, mem_write and busy.
REQ-033 Reset SHALL immediately force to 0: rdata0, rdata1, mem_addr and mem_wdata.
REQ-034 Reset during BUSY or DONE SHALL abort the access with no ack; the round-robin pointer SHALL reset to "last granted = port 1".

Configuration
REQ-035 With ARB_FIXED_PRIO_EN defined, port 0 SHALL win every tie and the round-robin pointer SHALL be absent.
REQ-036 Without ARB_FIXED_PRIO_EN, ties SHALL go to the port not granted last, and the pointer SHALL update on every grant.

Verification
REQ-037 Reset, then req0=1, we0=0, addr0=0x10, mem_rdata=6, MEM_LAT=2 -> gnt0 in cycle 1, mem_read high in cycles 1-2, ack0 in cycle 3 with rdata0=6.
REQ-038 req1=1, we1=1, addr1=0x8, wdata1=0xAB -> mem_write high in exactly one cycle with mem_addr=0x8 and mem_wdata=0xAB; ack1 follows with rdata1=0.
REQ-039 req0 and req1 held high for 4 accesses, round-robin build -> grant order 0,1,0,1; fixed-priority build -> order 0,0,0,0 while req0 stays high.
REQ-040 Reset asserted in the second BUSY cycle -> mem_read low immediately, no ack, and the next request is served normally.
REQ-041 MEM_LAT=1 back-to-back reads on port 0 -> ack every 3 cycles, with busy low for one cycle between accesses.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter in front of one shared data memory.
// Each access holds the memory controls for MEM_LAT cycles, then acks.
// Ports: clk, reset (async, active high); per port reqN/weN/addrN/wdataN
// in, gntN/ackN/rdataN out; mem_addr/mem_wdata/mem_read/mem_write out,
// mem_rdata in; busy out (high whenever the FSM is not idle).
// Build option: define ARB_FIXED_PRIO_EN for fixed priority (port 0
// wins ties); otherwise ties alternate via a round-robin pointer.
module dmem_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              win_q, win_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic [DATA_W-1:0] res;
  logic              pick;
  logic              first;

`ifdef ARB_FIXED_PRIO_EN
  assign pick = ~req0;
`else
  // last_q = 1 means port 1 was granted last; a tie goes to the other.
  logic last_q, last_d;

  assign pick = (req0 & req1) ? ~last_q : req1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_q <= 1'b1;
    else       last_q <= last_d;
  end

  always_comb begin
    last_d = last_q;
    if (state_q == IDLE && (req0 | req1)) last_d = pick;
  end
`endif

  // Writes return zero on the acked port's rdata.
  assign res = we_q ? '0 : mem_rdata;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    win_d    = win_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          state_d = BUSY;
          win_d   = pick;
          we_d    = pick ? we1 : we0;
          addr_d  = pick ? addr1 : addr0;
          wdata_d = pick ? wdata1 : wdata0;
          cnt_d   = LAT_M1;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          if (win_q) rdata1_d = res;
          else       rdata0_d = res;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      win_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      win_q    <= win_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // The counter is loaded with MEM_LAT-1, so that value marks BUSY cycle 1.
  assign first     = (state_q == BUSY) && (cnt_q == LAT_M1);
  assign gnt0      = first & ~win_q;
  assign gnt1      = first & win_q;
  assign ack0      = (state_q == DONE) & ~win_q;
  assign ack1      = (state_q == DONE) & win_q;
  assign mem_read  = (state_q == BUSY) & ~we_q;
  assign mem_write = first & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors for dmem_arbiter.
// u_dut runs MEM_LAT=2, u_lat1 runs MEM_LAT=1 on the same inputs.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [63:0] addr0, addr1, wdata0, wdata1, mem_rdata;
  logic        gnt0, gnt1, ack0, ack1, mem_read, mem_write, busy;
  logic [63:0] rdata0, rdata1, mem_addr, mem_wdata;
  logic        gnt0_b, gnt1_b, ack0_b, ack1_b, mem_read_b, mem_write_b, busy_b;
  logic [63:0] rdata0_b, rdata1_b, mem_addr_b, mem_wdata_b;

  int total = 0;
  int bad = 0;
  logic [63:0] rd0_m = '0;
  logic [63:0] rd1_m = '0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(2)) u_dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(1)) u_lat1 (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0_b), .gnt1(gnt1_b), .ack0(ack0_b), .ack1(ack1_b),
    .rdata0(rdata0_b), .rdata1(rdata1_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_read(mem_read_b), .mem_write(mem_write_b),
    .mem_rdata(mem_rdata), .busy(busy_b)
  );

  typedef struct {
    logic        port;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] mdata;
    logic [63:0] exp_rd;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    req0 = ~v.port;
    req1 = v.port;
    we0 = v.we;
    we1 = v.we;
    addr0 = v.addr;
    addr1 = v.addr;
    wdata0 = v.wdata;
    wdata1 = v.wdata;
    mem_rdata = v.mdata;
    @(negedge clk);
    chk("gnt0", gnt0, !v.port);
    chk("gnt1", gnt1, v.port);
    chk("busy_b1", busy, 1);
    chk("mem_addr", mem_addr, v.addr);
    chk("mem_wdata", mem_wdata, v.wdata);
    chk("mem_read_b1", mem_read, !v.we);
    chk("mem_write_b1", mem_write, v.we);
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    chk("gnt_b2", gnt0 | gnt1, 0);
    chk("mem_read_b2", mem_read, !v.we);
    chk("mem_write_b2", mem_write, 0);
    chk("ack_b2", ack0 | ack1, 0);
    @(negedge clk);
    chk("ack0", ack0, !v.port);
    chk("ack1", ack1, v.port);
    chk("strobes_done", mem_read | mem_write, 0);
    chk("busy_done", busy, 1);
    if (v.port) begin
      chk("rdata1", rdata1, v.exp_rd);
      chk("rdata0_hold", rdata0, rd0_m);
      rd1_m = v.exp_rd;
    end else begin
      chk("rdata0", rdata0, v.exp_rd);
      chk("rdata1_hold", rdata1, rd1_m);
      rd0_m = v.exp_rd;
    end
    @(negedge clk);
    chk("busy_idle", busy, 0);
    chk("ack_idle", ack0 | ack1, 0);
    chk("addr_hold", mem_addr, v.addr);
  endtask

  initial begin
    int n;
    int gap;
    logic got;
    logic exp_p;
    vt[0] = '{1'b0, 1'b0, 64'h10, 64'h0, 64'h6, 64'h6};
    vt[1] = '{1'b1, 1'b1, 64'h8, 64'hAB, 64'h99, 64'h0};
    vt[2] = '{1'b1, 1'b0, 64'h20, 64'h0, 64'h55, 64'h55};
    vt[3] = '{1'b0, 1'b1, 64'h30, 64'h1234, 64'h77, 64'h0};
    vt[4] = '{1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0,
              64'hDEAD_BEEF_CAFE_F00D, 64'hDEAD_BEEF_CAFE_F00D};
    vt[5] = '{1'b1, 1'b1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0};

    reset = 1'b1;
    {req0, req1, we0, we1} = '0;
    {addr0, addr1, wdata0, wdata1, mem_rdata} = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_gnt", {gnt0, gnt1}, 0);
    chk("rst_ack", {ack0, ack1}, 0);
    chk("rst_strobe", {mem_read, mem_write}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", rdata0 | rdata1, 0);
    chk("rst_mem", mem_addr | mem_wdata, 0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vt[i]);

    // Request pulled before any clock edge sees it.
    @(negedge clk);
    req0 = 1'b1;
    #2 req0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("withdrawn_busy", busy, 0);
      chk("withdrawn_ack", ack0 | ack1, 0);
    end

    // Reset in the second BUSY cycle of a read.
    @(negedge clk);
    req0 = 1'b1;
    we0 = 1'b0;
    addr0 = 64'h40;
    mem_rdata = 64'h5A;
    @(negedge clk);
    chk("abort_gnt", gnt0, 1);
    req0 = 1'b0;
    @(negedge clk);
    chk("abort_pre_read", mem_read, 1);
    reset = 1'b1;
    #1;
    chk("abort_read", mem_read, 0);
    chk("abort_busy", busy, 0);
    chk("abort_rdata", rdata0 | rdata1, 0);
    chk("abort_mem", mem_addr | mem_wdata, 0);
    rd0_m = '0;
    rd1_m = '0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_noack", ack0 | ack1, 0);
    end
    run_vec('{1'b0, 1'b0, 64'h48, 64'h0, 64'h3C, 64'h3C});

    // Both ports requesting continuously, starting from a fresh pointer.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req0 = 1'b1;
    req1 = 1'b1;
    we0 = 1'b0;
    we1 = 1'b0;
    addr0 = 64'h100;
    addr1 = 64'h200;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      got = 1'b0;
      while (!got && n < 8) begin
        @(negedge clk);
        n++;
        got = gnt0 | gnt1;
      end
      if (!got) begin
        total++;
        bad++;
        $display("FAIL tie_timeout: no grant %0d in 8 cycles", i);
      end else begin
`ifdef ARB_FIXED_PRIO_EN
        exp_p = 1'b0;
`else
        exp_p = (i % 2 == 1);
`endif
        gap = (i == 0) ? 1 : 4;
        chk("tie_port", gnt1, exp_p);
        chk("tie_gap", n, gap);
        chk("tie_addr", mem_addr, exp_p ? 64'h200 : 64'h100);
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);

    // MEM_LAT=1 instance: back-to-back reads on port 0.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req0 = 1'b1;
    we0 = 1'b0;
    mem_rdata = 64'h77;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      chk("lat1_ack", ack0_b, (c % 3 == 2));
      chk("lat1_busy", busy_b, (c % 3 != 0));
      if (c % 3 == 2) chk("lat1_rdata", rdata0_b, 64'h77);
    end
    req0 = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
